// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Two-source round-robin burst arbiter for the FIFO write port.
// Revision : 1.0
// ============================================================================
module fifo_wr_arbiter #(
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic          wclk,
    input  logic          rst,
    input  logic          s0_valid,
    input  logic [DW-1:0] s0_data,
    output logic          s0_ready,
    input  logic          s1_valid,
    input  logic [DW-1:0] s1_data,
    output logic          s1_ready,
    input  logic          fifo_full,
    output logic          fifo_wen,
    output logic [DW-1:0] fifo_wdata,
    output logic [1:0]    grant,
    output logic          busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GNT0  = 2'd1;
    localparam logic [1:0] c_GNT1  = 2'd2;
    localparam logic [4:0] c_BURST = 5'(BURST);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_rr;
    logic       w_rr_nxt;

    logic w_own0;
    logic w_own1;
    logic w_own_valid;
    logic w_oth_valid;
    logic w_last;
    logic w_end;

    assign w_own0 = (r_state == c_GNT0);
    assign w_own1 = (r_state == c_GNT1);

    assign s0_ready   = w_own0 && !fifo_full && !rst;
    assign s1_ready   = w_own1 && !fifo_full && !rst;
    assign fifo_wen   = (s0_valid && s0_ready) || (s1_valid && s1_ready);
    assign fifo_wdata = w_own0 ? s0_data : (w_own1 ? s1_data : '0);
    assign grant      = {w_own1, w_own0};
    assign busy       = w_own0 | w_own1;

    assign w_own_valid = w_own0 ? s0_valid : s1_valid;
    assign w_oth_valid = w_own0 ? s1_valid : s0_valid;

    // A burst closes on its last word or as soon as the owner has nothing to send.
    assign w_last = fifo_wen && (({1'b0, r_cnt} + 5'd1) == c_BURST);
    assign w_end  = !w_own_valid || w_last;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr;
        case (r_state)
            c_IDLE: begin
                if (s0_valid && s1_valid) begin
                    w_state_nxt = r_rr ? c_GNT1 : c_GNT0;
                end else if (s0_valid) begin
                    w_state_nxt = c_GNT0;
                end else if (s1_valid) begin
                    w_state_nxt = c_GNT1;
                end
            end
            c_GNT0, c_GNT1: begin
                if (w_end) begin
                    w_cnt_nxt = 4'd0;
                    w_rr_nxt  = w_own0;
                    if (w_oth_valid) begin
                        w_state_nxt = w_own0 ? c_GNT1 : c_GNT0;
                    end else if (w_own_valid) begin
                        w_state_nxt = r_state;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end else if (fifo_wen) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge wclk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_rr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Cycle-table bench for fifo_wr_arbiter with a write-data scoreboard.
// Revision : 1.0
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int DW = 8;

    logic          wclk = 1'b0;
    logic          rst;
    logic          s0_valid;
    logic [DW-1:0] s0_data;
    logic          s0_ready;
    logic          s1_valid;
    logic [DW-1:0] s1_data;
    logic          s1_ready;
    logic          fifo_full;
    logic          fifo_wen;
    logic [DW-1:0] fifo_wdata;
    logic [1:0]    grant;
    logic          busy;

    fifo_wr_arbiter #(.DW(DW), .BURST(4)) dut (
        .wclk       (wclk),
        .rst        (rst),
        .s0_valid   (s0_valid),
        .s0_data    (s0_data),
        .s0_ready   (s0_ready),
        .s1_valid   (s1_valid),
        .s1_data    (s1_data),
        .s1_ready   (s1_ready),
        .fifo_full  (fifo_full),
        .fifo_wen   (fifo_wen),
        .fifo_wdata (fifo_wdata),
        .grant      (grant),
        .busy       (busy)
    );

    always #5 wclk = ~wclk;

    // One row per clock cycle: inputs for the cycle and the owner/write expected during it.
    typedef struct {
        logic       rst;
        logic       v0;
        logic       v1;
        logic       full;
        logic [1:0] gnt;
        logic       wen;
    } vec_t;

    vec_t          tbl[$];
    logic [DW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cur_row  = 0;

    task automatic add(input logic r, input logic v0, input logic v1, input logic f,
                       input logic [1:0] g, input logic w, input int reps);
        vec_t e;
        e.rst = r; e.v0 = v0; e.v1 = v1; e.full = f; e.gnt = g; e.wen = w;
        for (int k = 0; k < reps; k++) tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, cur_row, act, exp);
        end
    endtask

    initial begin
        int            n0;
        int            n1;
        logic [DW-1:0] w;

        // Reset held with both sources requesting.
        add(1, 1, 1, 0, 2'b00, 0, 2);
        // Contention: first grant to s0, then alternating four-word bursts.
        add(0, 1, 1, 0, 2'b00, 0, 1);
        add(0, 1, 1, 0, 2'b01, 1, 4);
        add(0, 1, 1, 0, 2'b10, 1, 4);
        add(0, 1, 1, 0, 2'b01, 1, 2);
        // FIFO full for five cycles mid-burst, then the last two words.
        add(0, 1, 1, 1, 2'b01, 0, 5);
        add(0, 1, 1, 0, 2'b01, 1, 2);
        // s1 drops after one word; ownership goes straight to s0.
        add(0, 1, 1, 0, 2'b10, 1, 1);
        add(0, 1, 0, 0, 2'b10, 0, 1);
        add(0, 1, 0, 0, 2'b01, 1, 1);
        add(0, 0, 0, 0, 2'b01, 0, 1);
        // Back in IDLE with rr pointing at s1.
        add(0, 1, 1, 0, 2'b00, 0, 1);
        add(0, 1, 1, 0, 2'b10, 1, 1);
        // Reset in the middle of an s1 burst.
        add(1, 1, 1, 0, 2'b10, 0, 1);
        add(0, 1, 1, 0, 2'b00, 0, 1);
        add(0, 1, 1, 0, 2'b01, 1, 4);
        add(0, 0, 1, 0, 2'b10, 1, 1);
        add(0, 1, 0, 0, 2'b10, 0, 1);
        // Lone s0 stream: re-granted with no gap after a full burst.
        add(0, 1, 0, 0, 2'b01, 1, 6);
        add(0, 1, 0, 1, 2'b01, 0, 1);
        add(0, 1, 0, 0, 2'b01, 1, 1);
        // Full while the BURST-th word is offered: it waits, grant stays.
        add(0, 1, 0, 1, 2'b01, 0, 1);
        add(0, 1, 0, 0, 2'b01, 1, 1);
        add(0, 1, 0, 0, 2'b01, 1, 1);
        add(0, 0, 0, 0, 2'b01, 0, 1);
        add(0, 0, 0, 0, 2'b00, 0, 2);

        n0 = 0;
        n1 = 0;
        rst = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0; fifo_full = 1'b0;
        s0_data = '0; s1_data = '0;
        @(posedge wclk);

        for (int i = 0; i < tbl.size(); i++) begin
            cur_row = i;
            @(posedge wclk);
            #1;
            rst       = tbl[i].rst;
            s0_valid  = tbl[i].v0;
            s1_valid  = tbl[i].v1;
            fifo_full = tbl[i].full;
            s0_data   = 8'h10 + DW'(n0);
            s1_data   = 8'h80 + DW'(n1);
            if (tbl[i].wen) begin
                exp_q.push_back(tbl[i].gnt[0] ? s0_data : s1_data);
                if (tbl[i].gnt[0]) n0++;
                else n1++;
            end
            @(negedge wclk);
            chk("grant", 32'(grant), 32'(tbl[i].gnt));
            chk("busy", 32'(busy), 32'(|tbl[i].gnt));
            chk("fifo_wen", 32'(fifo_wen), 32'(tbl[i].wen));
            chk("s0_ready", 32'(s0_ready), 32'(tbl[i].gnt[0] & ~tbl[i].full & ~tbl[i].rst));
            chk("s1_ready", 32'(s1_ready), 32'(tbl[i].gnt[1] & ~tbl[i].full & ~tbl[i].rst));
            if (fifo_wen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(fifo_wdata), 32'hFFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    chk("fifo_wdata", 32'(fifo_wdata), 32'(w));
                end
            end else begin
                if (tbl[i].wen && exp_q.size() != 0) w = exp_q.pop_front();
                if (grant === 2'b00) chk("idle_wdata", 32'(fifo_wdata), 32'h0);
            end
        end
        chk("words_left", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
